breakout_game_ctrl: RTL

Game-control and ball-physics stage directly upstream of the brick renderer/collision block. It owns the game state machine (IDLE/PLAY/WIN/END), moves the ball once per video frame, and reflects it off walls, paddle and bricks. It consumes the brick collision vector and the win flag, and produces ball position, game_state and the game_reset pulse.

---
 rtl/breakout_pkg.sv | 16 +
 rtl/breakout_game_ctrl_if.sv | 30 +++
 rtl/breakout_ball_motion.sv | 94 +++++++++
 rtl/breakout_game_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game: screen geometry, ball size and
// the game state encoding seen by the renderer and the top level.
package breakout_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int BALL_R = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_END  = 2'b11
    } game_state_e;

endpackage

// File: rtl/breakout_game_ctrl_if.sv
// Signal bundle between the game controller and its surroundings.
// Handshake semantics: there is no valid/ready pair here. frame_tick is a
// single-cycle strobe with no back-pressure; every other input is a level
// sampled on each clock, and every output is a registered level (game_reset
// is a single-cycle registered pulse).
interface breakout_game_ctrl_if;
    import breakout_pkg::*;

    logic        frame_tick;
    logic        key_start;
    logic [9:0]  paddle_x;
    logic [49:0] brick_collision;
    logic        win_sig;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    game_state_e game_state;
    logic        game_reset;
    logic [1:0]  ball_dir;   // debug view {dir_x, dir_y}, 1 = coordinate increasing

    modport master (
        output frame_tick, key_start, paddle_x, brick_collision, win_sig,
        input  ball_x, ball_y, game_state, game_reset, ball_dir
    );

    modport slave (
        input  frame_tick, key_start, paddle_x, brick_collision, win_sig,
        output ball_x, ball_y, game_state, game_reset, ball_dir
    );

endinterface

// File: rtl/breakout_ball_motion.sv
// Ball physics: wall/paddle/brick bounce evaluation, per-frame move and clamp.
// Direction bits use 1 = coordinate increasing (right / down).
module breakout_ball_motion
    import breakout_pkg::*;
#(
    parameter int BALL_SPEED    = 2,
    parameter int PADDLE_Y      = 440,
    parameter int PADDLE_HALF_W = 40,
    parameter int START_X       = 320,
    parameter int START_Y       = 400
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_en_i,     // advance one frame
    input  logic       load_start_i,  // serve position and direction
    input  logic       hit_i,         // a brick was hit since the last frame
    input  logic [9:0] paddle_x_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       dir_x_o,
    output logic       dir_y_o,
    output logic       bottom_o       // the candidate move touches the bottom edge
);

    localparam logic signed [10:0] STEP   = 11'(BALL_SPEED);
    localparam logic signed [10:0] X_LO   = 11'(BALL_R);
    localparam logic signed [10:0] X_HI   = 11'(H_RES - 1 - BALL_R);
    localparam logic signed [10:0] Y_LO   = 11'(BALL_R);
    localparam logic signed [10:0] Y_HI   = 11'(V_RES - 1 - BALL_R);
    localparam logic signed [10:0] PAD_LO = 11'(PADDLE_Y - BALL_R);
    localparam logic signed [10:0] PAD_HI = 11'(PADDLE_Y + BALL_SPEED + 1 - BALL_R);
    localparam logic signed [10:0] HALF_W = 11'(PADDLE_HALF_W);

    logic [9:0]         x_q, y_q, x_d, y_d;
    logic               dir_x_q, dir_y_q, dir_x_d, dir_y_d;
    logic signed [10:0] x_s, y_s, px_s, dx_s, adx_s, x_m, y_m;
    logic               paddle_hit;

    // Bounces on the current position first, then move and clamp to the screen.
    always_comb begin
        x_s     = $signed({1'b0, x_q});
        y_s     = $signed({1'b0, y_q});
        px_s    = $signed({1'b0, paddle_x_i});
        dx_s    = x_s - px_s;
        adx_s   = dx_s[10] ? -dx_s : dx_s;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        paddle_hit = 1'b0;

        if (x_s <= X_LO && !dir_x_q)
            dir_x_d = 1'b1;
        else if (x_s >= X_HI && dir_x_q)
            dir_x_d = 1'b0;

        if (y_s <= Y_LO && !dir_y_q)
            dir_y_d = 1'b1;

        if (dir_y_q && y_s >= PAD_LO && y_s < PAD_HI && adx_s <= HALF_W) begin
            dir_y_d    = 1'b0;
            paddle_hit = 1'b1;
        end

        // Any number of bricks reflect once; paddle plus brick still ends going up.
        if (hit_i)
            dir_y_d = paddle_hit ? 1'b0 : ~dir_y_d;

        x_m = dir_x_d ? x_s + STEP : x_s - STEP;
        y_m = dir_y_d ? y_s + STEP : y_s - STEP;
        x_d = (x_m < X_LO) ? 10'(X_LO) : (x_m > X_HI) ? 10'(X_HI) : 10'(x_m);
        y_d = (y_m < Y_LO) ? 10'(Y_LO) : (y_m > Y_HI) ? 10'(Y_HI) : 10'(y_m);
        bottom_o = (y_d >= 10'(Y_HI));
    end

    // Position/direction registers: serve on reset or load, else update per frame.
    always_ff @(posedge clk_i) begin
        if (rst_i || load_start_i) begin
            x_q     <= 10'(START_X);
            y_q     <= 10'(START_Y);
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b0;
        end else if (tick_en_i) begin
            x_q     <= x_d;
            y_q     <= y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign dir_x_o = dir_x_q;
    assign dir_y_o = dir_y_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game controller: start-button edge detect, game state machine,
// sticky brick-hit flag and the ball physics sub-block.
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int BALL_SPEED    = 2,
    parameter int PADDLE_Y      = 440,
    parameter int PADDLE_HALF_W = 40,
    parameter int START_X       = 320,
    parameter int START_Y       = 400
) (
    input  logic               vga_clk,
    input  logic               sys_rst,
    breakout_game_ctrl_if.slave bus
);

    game_state_e state_q;
    logic        key_q;
    logic        game_reset_q;
    logic        hit_q;
    logic        start_edge, any_hit, play_tick, load_start, bottom;
    logic [9:0]  x, y;
    logic        dir_x, dir_y;

    assign start_edge = bus.key_start & ~key_q;
    assign any_hit    = |bus.brick_collision;
    assign play_tick  = bus.frame_tick & (state_q == ST_PLAY);
    // Ball sits at the serve point throughout IDLE and is reloaded when leaving WIN/END.
    assign load_start = (state_q == ST_IDLE) |
                        (((state_q == ST_WIN) | (state_q == ST_END)) & start_edge);

    // Game FSM with registered state, reset pulse, key history and hit flag.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            key_q        <= 1'b0;
            game_reset_q <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            key_q        <= bus.key_start;
            game_reset_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // The pulse cycle is spent in IDLE; PLAY follows it.
                    if (game_reset_q) begin
                        state_q <= ST_PLAY;
                    end else if (start_edge) begin
                        game_reset_q <= 1'b1;
                        hit_q        <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    // Sticky until the frame consumes it; a hit on the tick cycle carries over.
                    if (bus.frame_tick)
                        hit_q <= any_hit;
                    else if (any_hit)
                        hit_q <= 1'b1;
                    if (bus.win_sig)
                        state_q <= ST_WIN;
                    else if (bus.frame_tick && bottom)
                        state_q <= ST_END;
                end
                ST_WIN, ST_END: begin
                    if (start_edge)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    breakout_ball_motion #(
        .BALL_SPEED    (BALL_SPEED),
        .PADDLE_Y      (PADDLE_Y),
        .PADDLE_HALF_W (PADDLE_HALF_W),
        .START_X       (START_X),
        .START_Y       (START_Y)
    ) u_motion (
        .clk_i        (vga_clk),
        .rst_i        (sys_rst),
        .tick_en_i    (play_tick),
        .load_start_i (load_start),
        .hit_i        (hit_q),
        .paddle_x_i   (bus.paddle_x),
        .x_o          (x),
        .y_o          (y),
        .dir_x_o      (dir_x),
        .dir_y_o      (dir_y),
        .bottom_o     (bottom)
    );

    assign bus.ball_x     = x;
    assign bus.ball_y     = y;
    assign bus.game_state = state_q;
    assign bus.game_reset = game_reset_q;
    assign bus.ball_dir   = {dir_x, dir_y};

endmodule
